// File: rtl/trb_pkg.sv
// Shared constants and types for the trace buffer logger.
package trb_pkg;

  localparam int TRB_WIDTH      = 8;
  localparam int TRB_DEPTH      = 256;
  localparam int TRB_ADDR_WIDTH = $clog2(TRB_DEPTH);

  localparam logic MODE_TRIGGER = 1'b0;
  localparam logic MODE_STREAM  = 1'b1;

  localparam logic [TRB_ADDR_WIDTH-1:0] PTR_ONE = {{(TRB_ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    POST    = 2'd2,
    STOPPED = 2'd3
  } logger_state_t;

  // Pointer increment; wrap is the natural overflow of the pointer width.
  function automatic logic [TRB_ADDR_WIDTH-1:0] ptr_inc(input logic [TRB_ADDR_WIDTH-1:0] p);
    return p + PTR_ONE;
  endfunction

endpackage

// File: rtl/trace_logger_if.sv
// Bundle of capture, buffer, grant and drain signals around trace_logger.
// master = environment side, slave = the logger itself.
interface trace_logger_if;
  import trb_pkg::*;

  logic                      MODE_I;
  logic                      TRG_EVENT_I;
  logic [TRB_ADDR_WIDTH-1:0] POST_COUNT_I;
  logic [TRB_WIDTH-1:0]      TRACE_DATA_I;
  logic                      TRACE_VALID_I;
  logic                      TRACE_READY_O;
  logic                      RW_TURN_I;
  logic                      WRITE_ALLOW_I;
  logic                      READ_ALLOW_I;
  logic [TRB_ADDR_WIDTH-1:0] WRITE_PTR_O;
  logic [TRB_ADDR_WIDTH-1:0] READ_PTR_O;
  logic                      WRITE_O;
  logic [TRB_WIDTH-1:0]      DATA_O;
  logic [TRB_WIDTH-1:0]      DATA_I;
  logic [TRB_WIDTH-1:0]      OUT_DATA_O;
  logic                      OUT_VALID_O;
  logic                      OUT_READY_I;
  logic                      STOPPED_O;
  logic                      OVERFLOW_O;

  modport master (
    output MODE_I, TRG_EVENT_I, POST_COUNT_I, TRACE_DATA_I, TRACE_VALID_I,
           RW_TURN_I, WRITE_ALLOW_I, READ_ALLOW_I, DATA_I, OUT_READY_I,
    input  TRACE_READY_O, WRITE_PTR_O, READ_PTR_O, WRITE_O, DATA_O,
           OUT_DATA_O, OUT_VALID_O, STOPPED_O, OVERFLOW_O
  );

  modport slave (
    input  MODE_I, TRG_EVENT_I, POST_COUNT_I, TRACE_DATA_I, TRACE_VALID_I,
           RW_TURN_I, WRITE_ALLOW_I, READ_ALLOW_I, DATA_I, OUT_READY_I,
    output TRACE_READY_O, WRITE_PTR_O, READ_PTR_O, WRITE_O, DATA_O,
           OUT_DATA_O, OUT_VALID_O, STOPPED_O, OVERFLOW_O
  );

endinterface

// File: rtl/trb_ptr_ctrl.sv
// Read/write pointer pair of the trace buffer with full/empty detection.
// When overwrite is enabled, a write into a full buffer drags the read
// pointer along so the oldest word is dropped.
module trb_ptr_ctrl
  import trb_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_wr_adv,
  input  logic                      i_rd_adv,
  input  logic                      i_ovw_en,
  output logic [TRB_ADDR_WIDTH-1:0] o_wr_ptr,
  output logic [TRB_ADDR_WIDTH-1:0] o_rd_ptr,
  output logic                      o_full,
  output logic                      o_empty,
  output logic                      o_overwrite
);

  logic [TRB_ADDR_WIDTH-1:0] r_wr_ptr;
  logic [TRB_ADDR_WIDTH-1:0] r_rd_ptr;
  logic                      w_rd_step;

  assign o_empty     = (r_rd_ptr == r_wr_ptr);
  assign o_full      = (ptr_inc(r_wr_ptr) == r_rd_ptr);
  assign o_overwrite = i_wr_adv & i_ovw_en & o_full;
  // Overwrite advance and read advance never coincide (no reads before STOPPED).
  assign w_rd_step   = i_rd_adv | o_overwrite;
  assign o_wr_ptr    = r_wr_ptr;
  assign o_rd_ptr    = r_rd_ptr;

  // Advance pointers on accepted writes / reads / overwrites.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= {TRB_ADDR_WIDTH{1'b0}};
      r_rd_ptr <= {TRB_ADDR_WIDTH{1'b0}};
    end else begin
      if (i_wr_adv) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_rd_step) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
    end
  end

endmodule

// File: rtl/trace_logger.sv
// Logger side of the trace buffer: captures trace words into a one-entry
// holding register, writes them during logger slots, reads buffered words
// back into a valid/ready output stream. Stream mode is lossless with
// backpressure; trigger mode overwrites the ring and stops a programmed
// number of words after the trigger.
module trace_logger
  import trb_pkg::*;
(
  input  logic          CLK_I,
  input  logic          RST_I,
  trace_logger_if.slave bus
);

  localparam logic [TRB_ADDR_WIDTH-1:0] CNT_ZERO = {TRB_ADDR_WIDTH{1'b0}};

  logger_state_t             r_state;
  logger_state_t             w_next_state;
  logic                      r_mode;
  logic [TRB_ADDR_WIDTH-1:0] r_cnt;
  logic                      r_hold_valid;
  logic [TRB_WIDTH-1:0]      r_hold_data;
  logic                      r_out_valid;
  logic [TRB_WIDTH-1:0]      r_out_data;
  logic                      r_overflow;

  logic                      w_capture_open;
  logic                      w_trace_ready;
  logic                      w_accept;
  logic                      w_write;
  logic                      w_read;
  logic                      w_read_phase;
  logic                      w_ovw_en;
  logic                      w_trigger;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_overwrite;
  logic [TRB_ADDR_WIDTH-1:0] w_wr_ptr;
  logic [TRB_ADDR_WIDTH-1:0] w_rd_ptr;

  assign w_capture_open = (r_state == RUN) || (r_state == POST);
  assign w_trace_ready  = ~r_hold_valid & w_capture_open;
  assign w_accept       = bus.TRACE_VALID_I & w_trace_ready;
  assign w_ovw_en       = (r_mode == MODE_TRIGGER);

  // Write slot: logger turn, grant, a held word, and room (or ring overwrite).
  assign w_write = ~bus.RW_TURN_I & bus.WRITE_ALLOW_I & r_hold_valid & w_capture_open
                 & (~w_full | w_ovw_en);

  // Trigger mode only drains once capture has stopped.
  assign w_read_phase = (r_mode == MODE_STREAM) ? (r_state == RUN) : (r_state == STOPPED);
  assign w_read = ~bus.RW_TURN_I & bus.READ_ALLOW_I & ~w_empty & w_read_phase
                & (~r_out_valid | bus.OUT_READY_I);

  assign w_trigger = (r_state == RUN) & w_ovw_en & bus.TRG_EVENT_I;

  trb_ptr_ctrl u_ptr (
    .i_clk       (CLK_I),
    .i_rst       (RST_I),
    .i_wr_adv    (w_write),
    .i_rd_adv    (w_read),
    .i_ovw_en    (w_ovw_en),
    .o_wr_ptr    (w_wr_ptr),
    .o_rd_ptr    (w_rd_ptr),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_overwrite (w_overwrite)
  );

  // State register.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: IDLE->RUN, trigger handling, post-trigger countdown.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        w_next_state = RUN;
      end
      RUN: begin
        if (w_trigger) begin
          if (bus.POST_COUNT_I == CNT_ZERO) begin
            w_next_state = STOPPED;
          end else begin
            w_next_state = POST;
          end
        end else begin
          w_next_state = RUN;
        end
      end
      POST: begin
        if (w_write && (r_cnt == PTR_ONE)) begin
          w_next_state = STOPPED;
        end else begin
          w_next_state = POST;
        end
      end
      STOPPED: begin
        w_next_state = STOPPED;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Latch the operating mode when leaving IDLE.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_mode <= MODE_TRIGGER;
    end else if (r_state == IDLE) begin
      r_mode <= bus.MODE_I;
    end
  end

  // Post-trigger counter: loaded on the trigger, decremented per POST write.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_cnt <= CNT_ZERO;
    end else if (w_trigger) begin
      r_cnt <= bus.POST_COUNT_I;
    end else if ((r_state == POST) && w_write) begin
      r_cnt <= r_cnt - PTR_ONE;
    end
  end

  // One-entry holding register between capture port and buffer.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= {TRB_WIDTH{1'b0}};
    end else if (w_accept) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= bus.TRACE_DATA_I;
    end else if (w_write) begin
      r_hold_valid <= 1'b0;
    end
  end

  // Output register: load on a read slot, release when consumed.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {TRB_WIDTH{1'b0}};
    end else if (w_read) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.DATA_I;
    end else if (r_out_valid && bus.OUT_READY_I) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky flag: an unread word was overwritten.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_overflow <= 1'b0;
    end else if (w_overwrite) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.TRACE_READY_O = w_trace_ready;
  assign bus.WRITE_O       = w_write;
  assign bus.DATA_O        = r_hold_data;
  assign bus.WRITE_PTR_O   = w_wr_ptr;
  assign bus.READ_PTR_O    = w_rd_ptr;
  assign bus.OUT_DATA_O    = r_out_data;
  assign bus.OUT_VALID_O   = r_out_valid;
  assign bus.STOPPED_O     = (r_state == STOPPED);
  assign bus.OVERFLOW_O    = r_overflow;

endmodule

// File: tb/tb_trace_logger.sv
// Directed bench for trace_logger with a behavioural trace buffer memory.
module tb_trace_logger;
  import trb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  trace_logger_if bus ();

  trace_logger dut (
    .CLK_I (clk),
    .RST_I (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [TRB_WIDTH-1:0] mem [0:TRB_DEPTH-1];
  logic [TRB_WIDTH-1:0] outq [$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_writes;
  int   n_sent;
  int   src_limit = 0;
  logic [TRB_WIDTH-1:0] src_base = 8'h00;
  logic rw_toggle = 1'b1;

  assign bus.DATA_I = mem[bus.READ_PTR_O];

  // Buffer memory, write/accept counters and drained-word log.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n_writes <= 0;
      n_sent   <= 0;
      outq.delete();
    end else begin
      if (bus.WRITE_O) begin
        mem[bus.WRITE_PTR_O] <= bus.DATA_O;
        n_writes <= n_writes + 1;
      end
      if (bus.TRACE_VALID_I && bus.TRACE_READY_O) n_sent <= n_sent + 1;
      if (bus.OUT_VALID_O && bus.OUT_READY_I) outq.push_back(bus.OUT_DATA_O);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive the next source word and slot at the falling edge.
  task automatic cyc();
    @(negedge clk);
    bus.TRACE_VALID_I = (n_sent < src_limit);
    bus.TRACE_DATA_I  = src_base + 8'(n_sent);
    if (rw_toggle) bus.RW_TURN_I = ~bus.RW_TURN_I;
    #1;
  endtask

  task automatic do_reset(input logic mode);
    @(negedge clk);
    rst = 1'b1;
    bus.MODE_I        = mode;
    bus.TRG_EVENT_I   = 1'b0;
    bus.POST_COUNT_I  = 8'd0;
    bus.TRACE_VALID_I = 1'b0;
    bus.RW_TURN_I     = 1'b0;
    bus.WRITE_ALLOW_I = 1'b1;
    bus.READ_ALLOW_I  = 1'b0;
    bus.OUT_READY_I   = 1'b0;
    rw_toggle = 1'b1;
    src_limit = 0;
    src_base  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " wptr"},  int'(bus.WRITE_PTR_O), 0);
    check({tag, " rptr"},  int'(bus.READ_PTR_O), 0);
    check({tag, " write"}, int'(bus.WRITE_O), 0);
    check({tag, " data"},  int'(bus.DATA_O), 0);
    check({tag, " trdy"},  int'(bus.TRACE_READY_O), 0);
    check({tag, " ovld"},  int'(bus.OUT_VALID_O), 0);
    check({tag, " odata"}, int'(bus.OUT_DATA_O), 0);
    check({tag, " stop"},  int'(bus.STOPPED_O), 0);
    check({tag, " ovf"},   int'(bus.OVERFLOW_O), 0);
  endtask

  initial begin
    bus.MODE_I        = 1'b1;
    bus.TRG_EVENT_I   = 1'b0;
    bus.POST_COUNT_I  = 8'd0;
    bus.TRACE_DATA_I  = 8'h00;
    bus.TRACE_VALID_I = 1'b0;
    bus.RW_TURN_I     = 1'b0;
    bus.WRITE_ALLOW_I = 1'b1;
    bus.READ_ALLOW_I  = 1'b0;
    bus.OUT_READY_I   = 1'b0;

    // Reset values
    #12;
    check_reset_outputs("rst");

    // Stream fill: 300 words offered, no reads
    do_reset(1'b1);
    src_limit = 300;
    repeat (700) cyc();
    check("fill writes", n_writes, 255);
    check("fill sent", n_sent, 256);
    check("fill wptr", int'(bus.WRITE_PTR_O), 255);
    check("fill rptr", int'(bus.READ_PTR_O), 0);
    check("fill trdy", int'(bus.TRACE_READY_O), 0);
    check("fill ovf", int'(bus.OVERFLOW_O), 0);
    check("fill outs", outq.size(), 0);

    // Stream drain: everything comes out in order
    bus.READ_ALLOW_I = 1'b1;
    bus.OUT_READY_I  = 1'b1;
    for (int i = 0; i < 2000 && outq.size() < 300; i++) cyc();
    repeat (6) cyc();
    check("drain count", outq.size(), 300);
    for (int k = 0; k < outq.size() && k < 300; k++)
      check("drain word", int'(outq[k]), k % 256);
    check("drain writes", n_writes, 300);
    check("drain wptr", int'(bus.WRITE_PTR_O), 44);
    check("drain rptr", int'(bus.READ_PTR_O), 44);
    check("drain ovld", int'(bus.OUT_VALID_O), 0);
    check("drain ovf", int'(bus.OVERFLOW_O), 0);

    // Trigger overwrite: 301 words, trigger, 10 more, then drain
    do_reset(1'b0);
    bus.READ_ALLOW_I = 1'b1;
    bus.OUT_READY_I  = 1'b1;
    src_limit = 301;
    for (int i = 0; i < 2000 && n_writes < 301; i++) cyc();
    check("trg pre writes", n_writes, 301);
    check("trg pre wptr", int'(bus.WRITE_PTR_O), 45);
    check("trg pre rptr", int'(bus.READ_PTR_O), 46);
    check("trg pre outs", outq.size(), 0);
    check("trg pre ovf", int'(bus.OVERFLOW_O), 1);
    check("trg pre stop", int'(bus.STOPPED_O), 0);
    bus.TRG_EVENT_I  = 1'b1;
    bus.POST_COUNT_I = 8'd10;
    src_limit = 400;
    cyc();
    bus.TRG_EVENT_I = 1'b0;
    for (int i = 0; i < 200 && !bus.STOPPED_O; i++) cyc();
    check("trg stop", int'(bus.STOPPED_O), 1);
    check("trg writes", n_writes, 311);
    check("trg sent", n_sent, 311);
    check("trg trdy", int'(bus.TRACE_READY_O), 0);
    for (int i = 0; i < 2000 && outq.size() < 255; i++) cyc();
    repeat (6) cyc();
    check("trg count", outq.size(), 255);
    for (int k = 0; k < outq.size() && k < 255; k++)
      check("trg word", int'(outq[k]), (56 + k) % 256);
    check("trg wptr", int'(bus.WRITE_PTR_O), 55);
    check("trg rptr", int'(bus.READ_PTR_O), 55);
    check("trg ovf", int'(bus.OVERFLOW_O), 1);
    check("trg writes end", n_writes, 311);

    // Immediate stop: trigger with zero post count
    do_reset(1'b0);
    src_limit = 5;
    for (int i = 0; i < 100 && n_writes < 5; i++) cyc();
    check("imm pre writes", n_writes, 5);
    bus.TRG_EVENT_I  = 1'b1;
    bus.POST_COUNT_I = 8'd0;
    src_limit = 10;
    cyc();
    bus.TRG_EVENT_I = 1'b0;
    check("imm stop", int'(bus.STOPPED_O), 1);
    repeat (20) cyc();
    check("imm writes", n_writes, 5);
    check("imm wptr", int'(bus.WRITE_PTR_O), 5);
    check("imm write", int'(bus.WRITE_O), 0);
    check("imm trdy", int'(bus.TRACE_READY_O), 0);

    // Grant gating: no write grant, then system slot held
    do_reset(1'b1);
    bus.WRITE_ALLOW_I = 1'b0;
    src_limit = 10;
    repeat (20) cyc();
    check("gate wa writes", n_writes, 0);
    check("gate wa sent", n_sent, 1);
    check("gate wa trdy", int'(bus.TRACE_READY_O), 0);
    check("gate wa wptr", int'(bus.WRITE_PTR_O), 0);
    bus.WRITE_ALLOW_I = 1'b1;
    rw_toggle = 1'b0;
    bus.RW_TURN_I = 1'b1;
    repeat (10) cyc();
    check("gate rw writes", n_writes, 0);
    check("gate rw wptr", int'(bus.WRITE_PTR_O), 0);
    check("gate rw sent", n_sent, 1);

    // Reset mid-drain, then fresh capture
    do_reset(1'b1);
    src_limit = 20;
    for (int i = 0; i < 200 && n_writes < 20; i++) cyc();
    bus.READ_ALLOW_I = 1'b1;
    bus.OUT_READY_I  = 1'b1;
    for (int i = 0; i < 100 && outq.size() < 5; i++) cyc();
    check("mid outs", outq.size(), 5);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid");
    src_base  = 8'hA0;
    src_limit = 3;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100 && outq.size() < 3; i++) cyc();
    repeat (4) cyc();
    check("mid new count", outq.size(), 3);
    if (outq.size() > 0) check("mid first", int'(outq[0]), 160);
    else check("mid first", -1, 160);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
